// File: rtl/instr_dispatch_if.sv
// ----------------------------------------------------------------------------
// instr_dispatch_if
//   Handshake bundle between an instruction source, the dispatcher and the
//   three execution units (EU, BIU, FCU).
//
//   Ports of the bundle:
//     start                  dispatch request from the source
//     ir[IR_W-1:0]           instruction word from the source
//     ready_eu/biu/fcu       per-unit completion acknowledges
//     cs_eu/biu/fcu          per-unit selects from the dispatcher
//     sel_eu[1:0]            EU op code (00 arith_i, 01 arith, 10 comp)
//     sel_biu                BIU op code (0 mov, 1 l_st)
//     sel_fcu                FCU op code (0 branch)
//     idle                   dispatcher can accept start
//     done                   one-cycle completion pulse
//     err                    one-cycle error pulse
//     err_code[1:0]          cause of last error (01 illegal, 10 timeout)
//
//   Modports: master = source/units side, slave = dispatcher side.
// ----------------------------------------------------------------------------
interface instr_dispatch_if #(
  parameter int IR_W = 32
);
  logic            start;
  logic [IR_W-1:0] ir;
  logic            ready_eu;
  logic            ready_biu;
  logic            ready_fcu;
  logic            cs_eu;
  logic            cs_biu;
  logic            cs_fcu;
  logic [1:0]      sel_eu;
  logic            sel_biu;
  logic            sel_fcu;
  logic            idle;
  logic            done;
  logic            err;
  logic [1:0]      err_code;

  modport master (
    output start, ir, ready_eu, ready_biu, ready_fcu,
    input  cs_eu, cs_biu, cs_fcu, sel_eu, sel_biu, sel_fcu,
    input  idle, done, err, err_code
  );

  modport slave (
    input  start, ir, ready_eu, ready_biu, ready_fcu,
    output cs_eu, cs_biu, cs_fcu, sel_eu, sel_biu, sel_fcu,
    output idle, done, err, err_code
  );
endinterface

// File: rtl/instr_dispatch.sv
// ----------------------------------------------------------------------------
// instr_dispatch
//   Latches an instruction on an accepted start, decodes its prefix-coded
//   opcode field ir[OPC_MSB:OPC_MSB-5], selects one execution unit and waits
//   for that unit's ready, then pulses done (or err for an illegal opcode).
//
//   Ports:
//     clk   sole clock, rising edge
//     rst   asynchronous active-high reset
//     bus   instr_dispatch_if.slave (start, ir, ready_*, cs_*, sel_*,
//           idle, done, err, err_code)
//
//   All outputs are flops computed from the current state, so each output
//   trails the state register by one cycle: a start at edge 0 shows cs after
//   edge 2, and with ready already high done follows after edge 3.
//
//   Optional feature: define DISPATCH_TIMEOUT_EN to bound WAIT to TIMEOUT
//   cycles; on expiry the FSM goes to ERR with err_code 10.  Without the
//   macro WAIT is unbounded and no counter exists.
// ----------------------------------------------------------------------------
module instr_dispatch #(
  parameter int IR_W    = 32,
  parameter int OPC_MSB = 21,
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input logic               clk,
  input logic               rst,
  instr_dispatch_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WAIT   = 3'd2,
    S_DONE   = 3'd3,
    S_ERR    = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    C_ARITH_I = 3'd0,
    C_MOV     = 3'd1,
    C_LST     = 3'd2,
    C_BRANCH  = 3'd3,
    C_ARITH   = 3'd4,
    C_COMP    = 3'd5,
    C_ILL     = 3'd6
  } cls_e;

  // Prefix code: the first zero bit from the top selects the class.
  function automatic cls_e decode_opc(input logic [5:0] o);
    cls_e c;
    if (o[5] == 1'b0)      c = C_ARITH_I;
    else if (o[4] == 1'b0) c = C_MOV;
    else if (o[3] == 1'b0) c = C_LST;
    else if (o[2] == 1'b0) c = C_BRANCH;
    else if (o[1] == 1'b0) c = C_ARITH;
    else if (o[0] == 1'b0) c = C_COMP;
    else                   c = C_ILL;
    return c;
  endfunction

  state_e      state_q, state_d;
  logic [5:0]  opc_q, opc_d;
  logic [2:0]  cs_q, cs_d;          // {fcu, biu, eu}
  logic [1:0]  sel_eu_q, sel_eu_d;
  logic        sel_biu_q, sel_biu_d;
  logic        sel_fcu_q, sel_fcu_d;
  logic        idle_q, idle_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;

  cls_e        cls_s;
  logic [2:0]  cs_sel_s;
  logic [1:0]  sel_eu_s;
  logic        sel_biu_s;
  logic        rdy_sel_s;

`ifdef DISPATCH_TIMEOUT_EN
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
  logic [TO_W-1:0] cnt_q, cnt_d;
`endif

  assign cls_s = decode_opc(opc_q);

  // Map the decoded class to its unit select, op code and ready source.
  always_comb begin
    cs_sel_s  = 3'b000;
    sel_eu_s  = 2'b00;
    sel_biu_s = 1'b0;
    rdy_sel_s = 1'b0;
    case (cls_s)
      C_ARITH_I: begin cs_sel_s = 3'b001; sel_eu_s = 2'b00; rdy_sel_s = bus.ready_eu;  end
      C_ARITH:   begin cs_sel_s = 3'b001; sel_eu_s = 2'b01; rdy_sel_s = bus.ready_eu;  end
      C_COMP:    begin cs_sel_s = 3'b001; sel_eu_s = 2'b10; rdy_sel_s = bus.ready_eu;  end
      C_MOV:     begin cs_sel_s = 3'b010; sel_biu_s = 1'b0; rdy_sel_s = bus.ready_biu; end
      C_LST:     begin cs_sel_s = 3'b010; sel_biu_s = 1'b1; rdy_sel_s = bus.ready_biu; end
      C_BRANCH:  begin cs_sel_s = 3'b100;                   rdy_sel_s = bus.ready_fcu; end
      default:   begin cs_sel_s = 3'b000;                   rdy_sel_s = 1'b0;          end
    endcase
  end

  // Next-state and next-output logic of the dispatch FSM.
  always_comb begin
    state_d    = state_q;
    opc_d      = opc_q;
    cs_d       = 3'b000;
    sel_eu_d   = 2'b00;
    sel_biu_d  = 1'b0;
    sel_fcu_d  = 1'b0;
    idle_d     = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
`ifdef DISPATCH_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        idle_d = 1'b1;
        if (bus.start) begin
          opc_d   = bus.ir[OPC_MSB:OPC_MSB-5];
          state_d = S_DECODE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DECODE: begin
`ifdef DISPATCH_TIMEOUT_EN
        cnt_d = '0;
`endif
        if (cls_s == C_ILL) state_d = S_ERR;
        else                state_d = S_WAIT;
      end
      S_WAIT: begin
        cs_d      = cs_sel_s;
        sel_eu_d  = sel_eu_s;
        sel_biu_d = sel_biu_s;
        // Ready has priority over a timeout landing on the same edge.
        if (rdy_sel_s) begin
          state_d = S_DONE;
`ifdef DISPATCH_TIMEOUT_EN
        end else if (cnt_q == TO_LAST) begin
          state_d = S_ERR;
        end else begin
          state_d = S_WAIT;
          cnt_d   = cnt_q + TO_ONE;
        end
`else
        end else begin
          state_d = S_WAIT;
        end
`endif
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        err_d = 1'b1;
        // ERR is reached only by an illegal opcode or by a WAIT timeout.
        if (cls_s == C_ILL) err_code_d = 2'b01;
        else                err_code_d = 2'b10;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, latched opcode and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      opc_q      <= 6'b000000;
      cs_q       <= 3'b000;
      sel_eu_q   <= 2'b00;
      sel_biu_q  <= 1'b0;
      sel_fcu_q  <= 1'b0;
      idle_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      opc_q      <= opc_d;
      cs_q       <= cs_d;
      sel_eu_q   <= sel_eu_d;
      sel_biu_q  <= sel_biu_d;
      sel_fcu_q  <= sel_fcu_d;
      idle_q     <= idle_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  // WAIT cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`endif

  assign bus.cs_eu    = cs_q[0];
  assign bus.cs_biu   = cs_q[1];
  assign bus.cs_fcu   = cs_q[2];
  assign bus.sel_eu   = sel_eu_q;
  assign bus.sel_biu  = sel_biu_q;
  assign bus.sel_fcu  = sel_fcu_q;
  assign bus.idle     = idle_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.err_code = err_code_q;

endmodule

// File: tb/tb_instr_dispatch.sv
// ----------------------------------------------------------------------------
// tb_instr_dispatch
//   Directed stimulus with hand-computed expectations for instr_dispatch.
//   Inputs are driven 1 time unit after a rising edge; outputs are sampled
//   at the same point.  "edge N" below counts from the edge that accepts
//   start (edge 0).
// ----------------------------------------------------------------------------
module tb_instr_dispatch;
  localparam int IR_W = 32;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  instr_dispatch_if #(.IR_W(IR_W)) bus ();

  instr_dispatch #(
    .IR_W(IR_W), .OPC_MSB(21), .TO_W(8), .TIMEOUT(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] make_ir(input logic [5:0] o);
    logic [31:0] v;
    v = 32'hA5A5_A5A5;
    v[21:16] = o;
    return v;
  endfunction

  // Present an instruction, let edge 0 accept it, then scramble ir.
  task automatic launch(input logic [5:0] o);
    bus.ir    = make_ir(o);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.ir    = make_ir(6'b111111);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      if (bus.idle !== 1'b1) tick();
    end
    check_eq("wait_idle", {31'd0, bus.idle}, 32'd1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.ir = 32'd0;
    bus.ready_eu = 1'b0;
    bus.ready_biu = 1'b0;
    bus.ready_fcu = 1'b0;
    tick();
    tick();
    // Reset values
    check_eq("rst_idle", {31'd0, bus.idle}, 32'd1);
    check_eq("rst_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd0);
    check_eq("rst_sel", {28'd0, bus.sel_eu, bus.sel_biu, bus.sel_fcu}, 32'd0);
    check_eq("rst_done_err", {30'd0, bus.done, bus.err}, 32'd0);
    check_eq("rst_err_code", {30'd0, bus.err_code}, 32'd0);
    rst = 1'b0;

    // arith_i with ready already high; start held over edge 1 is ignored,
    // ir change after edge 0 has no effect.
    bus.ir = make_ir(6'b011111);
    bus.start = 1'b1;
    bus.ready_eu = 1'b1;
    tick();                                   // edge 0
    bus.ir = make_ir(6'b111111);
    check_eq("ai_e0_cs", {31'd0, bus.cs_eu}, 32'd0);
    tick();                                   // edge 1
    bus.start = 1'b0;
    check_eq("ai_e1_cs", {31'd0, bus.cs_eu}, 32'd0);
    check_eq("ai_e1_idle", {31'd0, bus.idle}, 32'd0);
    tick();                                   // edge 2
    check_eq("ai_e2_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd1);
    check_eq("ai_e2_sel", {30'd0, bus.sel_eu}, 32'd0);
    check_eq("ai_e2_done", {31'd0, bus.done}, 32'd0);
    tick();                                   // edge 3
    check_eq("ai_e3_done", {31'd0, bus.done}, 32'd1);
    check_eq("ai_e3_cs", {31'd0, bus.cs_eu}, 32'd0);
    tick();                                   // edge 4
    check_eq("ai_e4_done", {31'd0, bus.done}, 32'd0);
    check_eq("ai_e4_idle", {31'd0, bus.idle}, 32'd1);
    tick();                                   // no queued second dispatch
    check_eq("ai_noq_cs", {31'd0, bus.cs_eu}, 32'd0);
    bus.ready_eu = 1'b0;

    // comp, ready_eu rises after edge 6 -> cs held edges 2..7 (6 cycles)
    launch(6'b111110);
    tick();                                   // edge 1
    for (int i = 0; i < 6; i++) begin
      tick();                                 // edges 2..7
      check_eq("cmp_cs", {31'd0, bus.cs_eu}, 32'd1);
      check_eq("cmp_sel", {30'd0, bus.sel_eu}, 32'd2);
      check_eq("cmp_done_lo", {31'd0, bus.done}, 32'd0);
      if (i == 4) bus.ready_eu = 1'b1;
    end
    tick();                                   // edge 8
    check_eq("cmp_done", {31'd0, bus.done}, 32'd1);
    check_eq("cmp_cs_off", {31'd0, bus.cs_eu}, 32'd0);
    bus.ready_eu = 1'b0;
    tick();
    check_eq("cmp_done_1cyc", {31'd0, bus.done}, 32'd0);
    wait_idle();

    // l_st, foreign readies ignored
    bus.ready_eu = 1'b1;
    bus.ready_fcu = 1'b1;
    launch(6'b110000);
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();                                 // edges 2..5
      check_eq("lst_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd2);
      check_eq("lst_sel", {31'd0, bus.sel_biu}, 32'd1);
      check_eq("lst_done_lo", {31'd0, bus.done}, 32'd0);
    end
    bus.ready_biu = 1'b1;
    tick();                                   // edge 6
    check_eq("lst_e6_cs", {31'd0, bus.cs_biu}, 32'd1);
    tick();                                   // edge 7
    check_eq("lst_done", {31'd0, bus.done}, 32'd1);
    check_eq("lst_cs_off", {31'd0, bus.cs_biu}, 32'd0);
    bus.ready_eu = 1'b0;
    bus.ready_fcu = 1'b0;
    bus.ready_biu = 1'b0;
    wait_idle();

    // mov
    bus.ready_biu = 1'b1;
    launch(6'b100101);
    tick();
    tick();
    check_eq("mov_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd2);
    check_eq("mov_sel", {31'd0, bus.sel_biu}, 32'd0);
    tick();
    check_eq("mov_done", {31'd0, bus.done}, 32'd1);
    bus.ready_biu = 1'b0;
    wait_idle();

    // arith
    bus.ready_eu = 1'b1;
    launch(6'b111101);
    tick();
    tick();
    check_eq("ar_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd1);
    check_eq("ar_sel", {30'd0, bus.sel_eu}, 32'd1);
    tick();
    check_eq("ar_done", {31'd0, bus.done}, 32'd1);
    bus.ready_eu = 1'b0;
    wait_idle();

    // branch with ready_fcu held low
    launch(6'b111000);
    tick();
`ifdef DISPATCH_TIMEOUT_EN
    for (int i = 0; i < 16; i++) begin
      tick();                                 // edges 2..17
      check_eq("br_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd4);
      check_eq("br_sel", {31'd0, bus.sel_fcu}, 32'd0);
      check_eq("br_err_lo", {31'd0, bus.err}, 32'd0);
    end
    tick();                                   // edge 18
    check_eq("to_err", {31'd0, bus.err}, 32'd1);
    check_eq("to_code", {30'd0, bus.err_code}, 32'd2);
    check_eq("to_cs_off", {31'd0, bus.cs_fcu}, 32'd0);
    tick();
    check_eq("to_err_1cyc", {31'd0, bus.err}, 32'd0);
`else
    for (int i = 0; i < 20; i++) begin
      tick();                                 // edges 2..21
      check_eq("br_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd4);
      check_eq("br_sel", {31'd0, bus.sel_fcu}, 32'd0);
      check_eq("br_err_lo", {31'd0, bus.err}, 32'd0);
    end
    bus.ready_fcu = 1'b1;
    tick();
    check_eq("br_cs_last", {31'd0, bus.cs_fcu}, 32'd1);
    tick();
    check_eq("br_done", {31'd0, bus.done}, 32'd1);
    bus.ready_fcu = 1'b0;
`endif
    wait_idle();

    // illegal
    launch(6'b111111);
    tick();                                   // edge 1
    check_eq("ill_e1_err", {31'd0, bus.err}, 32'd0);
    tick();                                   // edge 2
    check_eq("ill_err", {31'd0, bus.err}, 32'd1);
    check_eq("ill_code", {30'd0, bus.err_code}, 32'd1);
    check_eq("ill_cs", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd0);
    tick();
    check_eq("ill_err_1cyc", {31'd0, bus.err}, 32'd0);
    check_eq("ill_code_hold", {30'd0, bus.err_code}, 32'd1);
    wait_idle();

    // reset during WAIT with start held high throughout
    bus.ir = make_ir(6'b000000);
    bus.start = 1'b1;
    tick();
    tick();
    tick();
    check_eq("rw_cs_pre", {31'd0, bus.cs_eu}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rw_cs_async", {29'd0, bus.cs_fcu, bus.cs_biu, bus.cs_eu}, 32'd0);
    check_eq("rw_idle", {31'd0, bus.idle}, 32'd1);
    check_eq("rw_pulses", {30'd0, bus.done, bus.err}, 32'd0);
    check_eq("rw_code", {30'd0, bus.err_code}, 32'd0);
    tick();                                   // edge under reset
    rst = 1'b0;
    tick();                                   // first edge after release
    bus.start = 1'b0;
    check_eq("rw_e0_cs", {31'd0, bus.cs_eu}, 32'd0);
    tick();
    check_eq("rw_e1_cs", {31'd0, bus.cs_eu}, 32'd0);
    tick();
    check_eq("rw_e2_cs", {31'd0, bus.cs_eu}, 32'd1);
    bus.ready_eu = 1'b1;
    tick();
    tick();
    check_eq("rw_done", {31'd0, bus.done}, 32'd1);
    bus.ready_eu = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
